// File: rtl/icb_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icb_sram_responder_pkg
//  Description : Shared ICB definitions. Holds the bus width constants and
//                the response-queue entry type.
//                Constants:
//                  c_AW - ICB address width
//                  c_DW - ICB data width
//                  c_BW - number of byte lanes (c_DW/8)
//                Types:
//                  rsp_entry_t - one queued response {err, rdata}
//  Revision    : 1.0 - initial release
// ============================================================================
package icb_sram_responder_pkg;

    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_BW = c_DW / 8;

    // One queued response. Errors and writes always carry rdata = 0.
    typedef struct packed {
        logic            err;
        logic [c_DW-1:0] rdata;
    } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/icb_rsp_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : icb_rsp_fifo2
//  Description : Two-entry in-order response FIFO for ICB responders.
//                The head entry is presented combinationally.
//                Ports:
//                  clk, rst_n             - clock, synchronous active-low reset
//                  push, push_err/rdata   - enqueue one response
//                  pop                    - dequeue the head entry
//                  head_err/head_rdata    - current head entry
//                  full, empty, count     - occupancy status (count 0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module icb_rsp_fifo2
    import icb_sram_responder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            push_err,
    input  logic [c_DW-1:0] push_rdata,
    input  logic            pop,
    output logic            head_err,
    output logic [c_DW-1:0] head_rdata,
    output logic            full,
    output logic            empty,
    output logic [1:0]      count
);

    rsp_entry_t r_entry [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_push;
    logic       w_pop;

    // Overflowing pushes and underflowing pops are ignored.
    assign w_push = push && (r_count != 2'd2);
    assign w_pop  = pop  && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Both entries are cleared so the head reads as zero after reset.
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_push) begin
                r_entry[r_wr_ptr] <= '{err: push_err, rdata: push_rdata};
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_err   = r_entry[r_rd_ptr].err;
    assign head_rdata = r_entry[r_rd_ptr].rdata;
    assign full       = (r_count == 2'd2);
    assign empty      = (r_count == 2'd0);
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/icb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icb_sram_responder
//  Description : ICB responder backed by a word-organised SRAM with byte-lane
//                write enables. Responses are queued in a 2-entry FIFO so the
//                initiator may stall icb_rsp_ready without data loss.
//                Ports:
//                  clk, rst_n      - clock, synchronous active-low reset
//                  icb_cmd_*       - command channel (valid/ready, addr,
//                                    read, wdata, wmask)
//                  icb_rsp_*       - response channel (valid/ready, err,
//                                    rdata)
//  Revision    : 1.0 - initial release
// ============================================================================
module icb_sram_responder
    import icb_sram_responder_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            DEPTH     = 1024,
    parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic            icb_rsp_err,
    output logic [DW-1:0]   icb_rsp_rdata
);

    localparam int c_IW = $clog2(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_hit;
    logic            w_accept;
    logic [c_IW-1:0] w_idx;
    logic [DW-1:0]   w_rd_word;
    logic            w_push_err;
    logic [DW-1:0]   w_push_rdata;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [1:0]      w_count;
    logic            w_unused;

    // BASE_ADDR is aligned to the array size, so a hit is simply a match of
    // the address bits above the word index.
    assign w_hit    = (icb_cmd_addr[AW-1:c_IW+2] == BASE_ADDR[AW-1:c_IW+2]);
    assign w_idx    = icb_cmd_addr[c_IW+1:2];

    // Ready depends only on reset and occupancy, never on icb_rsp_ready, so
    // the command channel has no combinational path from the response side.
    assign icb_cmd_ready = rst_n && (w_count < 2'd2);
    assign w_accept      = icb_cmd_valid && icb_cmd_ready;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_hit && !icb_cmd_read) begin
            for (int b = 0; b < DW/8; b++) begin
                if (icb_cmd_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous array read: the word is captured into the response entry
    // at the accepting edge, so a read right after a write sees new data.
    assign w_rd_word    = r_mem[w_idx];
    assign w_push_err   = !w_hit;
    assign w_push_rdata = (w_hit && icb_cmd_read) ? w_rd_word : '0;

    assign w_pop = icb_rsp_valid && icb_rsp_ready;

    icb_rsp_fifo2 u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_accept),
        .push_err   (w_push_err),
        .push_rdata (w_push_rdata),
        .pop        (w_pop),
        .head_err   (icb_rsp_err),
        .head_rdata (icb_rsp_rdata),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count)
    );

    assign icb_rsp_valid = !w_empty;

    // Byte offset bits are ignored; full status is implied by the count.
    assign w_unused = ^{icb_cmd_addr[1:0], w_full};

endmodule
`default_nettype wire

// File: tb/tb_icb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icb_sram_responder
//  Description : Directed self-checking bench for icb_sram_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icb_sram_responder;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    int errors = 0;
    int checks = 0;

    icb_sram_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated command with rsp_ready high: accepted immediately,
    // response visible one cycle later, popped the cycle after.
    task automatic issue(input string tag, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         input logic e_err, input logic [31:0] e_rdata);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = m;
        #1;
        chk1({tag, ".cmd_ready"}, icb_cmd_ready, 1'b1);
        tick();
        icb_cmd_valid = 1'b0;
        #1;
        chk1({tag, ".rsp_valid"}, icb_rsp_valid, 1'b1);
        chk1({tag, ".rsp_err"}, icb_rsp_err, e_err);
        chk32({tag, ".rsp_rdata"}, icb_rsp_rdata, e_rdata);
        tick();
        chk1({tag, ".rsp_drained"}, icb_rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b1;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        chk1("rst.cmd_ready", icb_cmd_ready, 1'b0);
        chk1("rst.rsp_valid", icb_rsp_valid, 1'b0);
        chk1("rst.rsp_err", icb_rsp_err, 1'b0);
        chk32("rst.rsp_rdata", icb_rsp_rdata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk1("rel.cmd_ready", icb_cmd_ready, 1'b1);
        tick();

        // ---------------- basic write / read ----------------
        issue("wr_beef", 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        issue("rd_beef", 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);

        // ---------------- byte masking ----------------
        issue("wr_full", 1'b0, 32'h8000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        issue("wr_mask", 1'b0, 32'h8000_0020, 32'hAAAA_AAAA, 4'b0101, 1'b0, 32'h0);
        issue("rd_mask", 1'b1, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 32'h11AA_33AA);
        issue("wr_m0", 1'b0, 32'h8000_0020, 32'h5555_5555, 4'h0, 1'b0, 32'h0);
        issue("rd_m0", 1'b1, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 32'h11AA_33AA);

        // ---------------- address range ----------------
        issue("rd_miss_hi", 1'b1, 32'h8000_1000, 32'h0, 4'h0, 1'b1, 32'h0);
        issue("rd_miss_lo", 1'b1, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0);
        issue("wr_miss", 1'b0, 32'h8000_1010, 32'h1234_5678, 4'hF, 1'b1, 32'h0);
        issue("rd_after_miss", 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        issue("wr_top", 1'b0, 32'h8000_0FFE, 32'h0BAD_C0DE, 4'hF, 1'b0, 32'h0);
        issue("rd_top", 1'b1, 32'h8000_0FFC, 32'h0, 4'h0, 1'b0, 32'h0BAD_C0DE);

        // ---------------- back-to-back read-after-write ----------------
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h8000_0030;
        icb_cmd_wdata = 32'hCAFE_F00D;
        icb_cmd_wmask = 4'hF;
        tick();
        icb_cmd_read = 1'b1;
        #1;
        chk1("raw.wr_rsp_valid", icb_rsp_valid, 1'b1);
        chk1("raw.cmd_ready", icb_cmd_ready, 1'b1);
        tick();
        icb_cmd_valid = 1'b0;
        #1;
        chk1("raw.rd_rsp_valid", icb_rsp_valid, 1'b1);
        chk32("raw.rd_rdata", icb_rsp_rdata, 32'hCAFE_F00D);
        tick();
        chk1("raw.drained", icb_rsp_valid, 1'b0);

        // ---------------- back-pressure ----------------
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h8000_0010;               // A
        #1;
        chk1("bp.ready_a", icb_cmd_ready, 1'b1);
        tick();
        icb_cmd_addr = 32'h8000_0020;                // B
        #1;
        chk1("bp.ready_b", icb_cmd_ready, 1'b1);
        chk32("bp.head_a", icb_rsp_rdata, 32'hDEAD_BEEF);
        tick();
        icb_cmd_addr = 32'h8000_0030;                // C
        #1;
        chk1("bp.ready_full", icb_cmd_ready, 1'b0);
        tick();
        #1;
        chk1("bp.ready_full2", icb_cmd_ready, 1'b0);
        chk1("bp.valid_stall", icb_rsp_valid, 1'b1);
        chk32("bp.head_stable", icb_rsp_rdata, 32'hDEAD_BEEF);
        icb_rsp_ready = 1'b1;
        #1;
        chk1("bp.ready_full_pop", icb_cmd_ready, 1'b0);
        tick();
        #1;
        chk32("bp.head_b", icb_rsp_rdata, 32'h11AA_33AA);
        chk1("bp.ready_after_pop", icb_cmd_ready, 1'b1);
        tick();                                      // accept C, pop B
        icb_cmd_addr = 32'h8000_0FFC;                // D
        #1;
        chk32("bp.head_c", icb_rsp_rdata, 32'hCAFE_F00D);
        chk1("bp.ready_d", icb_cmd_ready, 1'b1);
        tick();                                      // accept D, pop C
        icb_cmd_valid = 1'b0;
        #1;
        chk1("bp.valid_d", icb_rsp_valid, 1'b1);
        chk32("bp.head_d", icb_rsp_rdata, 32'h0BAD_C0DE);
        tick();
        chk1("bp.drained", icb_rsp_valid, 1'b0);

        // ---------------- streaming, 16 writes then 16 reads ----------------
        for (int i = 0; i < 16; i++) begin
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b0;
            icb_cmd_addr  = 32'h8000_0100 + 32'(4 * i);
            icb_cmd_wdata = 32'h0101_0101 * 32'(i + 1);
            icb_cmd_wmask = 4'hF;
            #1;
            chk1($sformatf("sw.ready%0d", i), icb_cmd_ready, 1'b1);
            tick();
            chk1($sformatf("sw.valid%0d", i), icb_rsp_valid, 1'b1);
            chk1($sformatf("sw.err%0d", i), icb_rsp_err, 1'b0);
        end
        icb_cmd_valid = 1'b0;
        tick();
        chk1("sw.drained", icb_rsp_valid, 1'b0);
        for (int i = 0; i < 16; i++) begin
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b1;
            icb_cmd_addr  = 32'h8000_0100 + 32'(4 * i);
            #1;
            chk1($sformatf("sr.ready%0d", i), icb_cmd_ready, 1'b1);
            tick();
            chk1($sformatf("sr.valid%0d", i), icb_rsp_valid, 1'b1);
            chk32($sformatf("sr.rdata%0d", i), icb_rsp_rdata, 32'h0101_0101 * 32'(i + 1));
        end
        icb_cmd_valid = 1'b0;
        tick();
        chk1("sr.drained", icb_rsp_valid, 1'b0);

        // ---------------- reset while full ----------------
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h9000_0000;               // miss, becomes head
        #1;
        chk1("rf.ready0", icb_cmd_ready, 1'b1);
        tick();
        icb_cmd_addr = 32'h8000_0020;
        tick();
        icb_cmd_valid = 1'b0;
        #1;
        chk1("rf.full", icb_cmd_ready, 1'b0);
        chk1("rf.head_err", icb_rsp_err, 1'b1);
        // A write presented during reset must not reach the array.
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h8000_0010;
        icb_cmd_wdata = 32'h0000_0000;
        icb_cmd_wmask = 4'hF;
        #1;
        chk1("rf.ready_in_rst", icb_cmd_ready, 1'b0);
        tick();
        chk1("rf.valid_cleared", icb_rsp_valid, 1'b0);
        chk1("rf.err_cleared", icb_rsp_err, 1'b0);
        chk32("rf.rdata_cleared", icb_rsp_rdata, 32'h0);
        rst_n         = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b1;
        #1;
        chk1("rf.ready_rel", icb_cmd_ready, 1'b1);
        chk1("rf.no_stale0", icb_rsp_valid, 1'b0);
        tick();
        chk1("rf.no_stale1", icb_rsp_valid, 1'b0);
        issue("rf.rd_keep0", 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        issue("rf.rd_keep1", 1'b1, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 32'h11AA_33AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
